inert_seq: RTL and testbench
============================

# inert_seq

Command sequencer sitting directly upstream of the SPI monarch: after reset it waits out the IMU power-up time, writes the IMU configuration registers, then on every data-ready interrupt reads the yaw-rate register pair and presents a 16-bit sample with a one-cycle valid strobe. It drives the monarch's `wrt`/`wt_data` and consumes its `done`/`rd_data`; all SPI pin-level timing stays in the monarch.

## Interface
- `INIT_CYCLES`, default 65536: clocks from reset release to the first configuration write (≥2).
- `clk` in 1: system clock.
- `rst` in 1: synchronous active-high reset.
- `INT` in 1: IMU data-ready interrupt, asynchronous, active-high.
- `done` in 1: monarch transaction-complete flag; sticky high until the monarch's next `wrt`.
- `rd_data` in 16: monarch receive word; the register byte is in `rd_data[7:0]`.
- `wrt` out 1: one-cycle start strobe to the monarch.
- `wt_data` out 16: command word, held stable from `wrt` until the matching `done` rise.
- `yaw` out 16: yaw-rate sample `{high, low}`, two's complement.
- `pitch`, `roll` out 16 each: pitch- and roll-rate samples (see Configuration).
- `vld` out 1: one-cycle strobe; sample outputs updated in the same cycle.
- `ready` out 1: high once configuration is finished; stays high until `rst`.

## Operation
- Register-read command: `{1'b1, addr[6:0], 8'h00}`. Register-write command: `{1'b0, addr[6:0], data[7:0]}`.
- Configuration writes, in order: `16'h0D02` (INT1 = gyro data-ready), `16'h1160` (gyro ODR 416 Hz), `16'h1440` (rounding).
- Yaw reads: `16'hA600` (low byte), then `16'hA700` (high byte).
- Transaction rule:
  - Assert `wrt` for exactly 1 cycle with `wt_data` valid in the same cycle.
  - Wait for a `done` rising edge: `done & ~done_q`, where `done_q` is `done` registered.
  - A `done` level already high when `wrt` issues must not complete the transaction.
- States:
  - `INIT_WAIT`: counts `INIT_CYCLES`.
  - `CFG1`, `CFG2`, `CFG3`: one configuration write each.
  - `IDLE`: `ready=1`; waits for an interrupt.
  - `RD_YL`, `RD_YH`: yaw reads.
  - `RD_PL`, `RD_PH`, `RD_RL`, `RD_RH`: pitch/roll reads; only with the macro.
  - `VLD`: updates the sample outputs and pulses `vld`.
  - `VLD` → `IDLE`.
- Every `RD_*L` state captures `rd_data[7:0]` into a low-byte holding register on its `done` rise.
- Every `RD_*H` state combines the captured high byte with the held low byte.
- `yaw`/`pitch`/`roll` change only in the `VLD` cycle, so the outputs never expose a torn high/low pair.
- `INT` path: 2-flop synchronizer, then rising-edge detect.
  - An edge sets a `pending` flag; `IDLE` consumes `pending`.
  - An edge during a read sequence sets `pending`; the next sequence starts immediately after `VLD`.
  - Multiple edges during one sequence collapse into one pending flag.
  - Edges before `ready` are discarded; `pending` is held clear until `ready`.
- Reset mid-transaction:
  - Returns to `INIT_WAIT` and clears all registers; the full configuration is redone.
  - Does not wait for the monarch; a stale `done` rise is ignored because `wrt` has not yet issued.

## Timing
- Reset values: `wrt=0`, `wt_data=16'h0000`, `yaw=pitch=roll=16'h0000`, `vld=0`, `ready=0`, `pending=0`.
- First `wrt`: exactly `INIT_CYCLES` clocks after the first cycle with `rst` low.
- Next `wrt`: 1 cycle after the state that saw the `done` rise (registered next-state decode).
- `INT` edge to the first read `wrt`, starting from `IDLE`: 4 cycles (2 sync, 1 edge/pending, 1 issue).
- Final `done` rise to `vld`: 2 cycles.
- `vld` is never high on two consecutive cycles.
- `wt_data` holds its value between transactions; it changes only in the `wrt` cycle.

## Configuration
- Macro: `INERT_PITCH_ROLL_EN`.
- Defined:
  - Read sequence is yaw, pitch (`A200`/`A300`), roll (`A400`/`A500`): 6 transactions.
  - `pitch`/`roll` update with `yaw` in the `VLD` cycle.
- Undefined:
  - Read sequence is yaw only: 2 transactions.
  - `pitch`/`roll` are constant `16'h0000`; `RD_PL` through `RD_RH` are not synthesized.

## Structure
- Package `inert_pkg` holds:
  - state enum `inert_state_t`;
  - configuration command constants `CFG_INT1`, `CFG_ODR`, `CFG_ROUND`;
  - read address constants `ADDR_YAW_L`, `ADDR_YAW_H`, `ADDR_PITCH_L`, `ADDR_PITCH_H`, `ADDR_ROLL_L`, `ADDR_ROLL_H`;
  - read-command function `rd_cmd(addr)`.
- Init counter width: `$clog2(INIT_CYCLES+1)`.
- Sub-module `int_sync`: 2-flop synchronizer plus rising-edge pulse; reused for any asynchronous pin.

## Test plan
- Reset, `INIT_CYCLES=16`, bench monarch model → `wrt` at cycle 16 with `0D02`, then `1160`, then `1440`; `ready` rises after the third `done` rise.
- `INT` pulse in `IDLE`; model returns `rd_data` `0x0034` then `0x0012` → `vld` pulse with `yaw=16'h1234`, and `vld` is 2 cycles after the last `done` rise.
- `done` held high from the previous transaction when `wrt` issues → no advance until `done` falls and rises again.
- Three `INT` edges during a read sequence → exactly one extra sequence after `VLD`, i.e. 2 `vld` pulses total.
- `rst` asserted mid-`RD_YH` → all outputs return to reset values; sequence restarts at `0D02` after `INIT_CYCLES`; `yaw` does not change before the new `vld`.
- With `INERT_PITCH_ROLL_EN` defined, reads return bytes `34,12,78,56,BC,9A` → `yaw=1234`, `pitch=5678`, `roll=9ABC`, one `vld` pulse.

Source files
------------

// File: rtl/inert_pkg.sv
// inert_pkg: shared state type, IMU command constants and a read-command
// helper for the inert_seq command sequencer.
//
// Command word layout toward the SPI monarch:
//   read  : {1'b1, addr[6:0], 8'h00}
//   write : {1'b0, addr[6:0], data[7:0]}
package inert_pkg;

  typedef enum logic [3:0] {
    StInitWait,
    StCfg1,
    StCfg2,
    StCfg3,
    StIdle,
    StRdYl,
    StRdYh,
    StRdPl,
    StRdPh,
    StRdRl,
    StRdRh,
    StVld
  } inert_state_t;

  // Configuration writes, issued once after power-up in this order.
  localparam logic [15:0] CFG_INT1  = 16'h0D02;  // INT1 pin = gyro data-ready
  localparam logic [15:0] CFG_ODR   = 16'h1160;  // gyro ODR 416 Hz
  localparam logic [15:0] CFG_ROUND = 16'h1440;  // rounding enable

  // Rate register pairs (low byte first).
  localparam logic [6:0] ADDR_YAW_L   = 7'h26;
  localparam logic [6:0] ADDR_YAW_H   = 7'h27;
  localparam logic [6:0] ADDR_PITCH_L = 7'h22;
  localparam logic [6:0] ADDR_PITCH_H = 7'h23;
  localparam logic [6:0] ADDR_ROLL_L  = 7'h24;
  localparam logic [6:0] ADDR_ROLL_H  = 7'h25;

  function automatic logic [15:0] rd_cmd(input logic [6:0] addr);
    return {1'b1, addr, 8'h00};
  endfunction

endpackage

// File: rtl/int_sync.sv
// int_sync: two-flop synchronizer for an asynchronous level input, followed by
// a rising-edge detector. Usable for any asynchronous pin.
//
// Ports:
//   clk     in  system clock
//   rst     in  synchronous active-high reset
//   async_i in  asynchronous input
//   rise_o  out one-cycle pulse on a synchronized 0->1 transition
module int_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/inert_seq.sv
// inert_seq: IMU command sequencer in front of the SPI monarch.
//
// After reset it waits INIT_CYCLES clocks, writes the three IMU configuration
// registers, then on every data-ready interrupt reads the rate register pairs
// and presents the samples with a one-cycle vld strobe. Pin-level SPI timing
// lives entirely in the monarch; this block only issues wrt/wt_data and
// watches done/rd_data.
//
// Build option: define INERT_PITCH_ROLL_EN to also read pitch and roll
// (6 transactions per sample). Without it only yaw is read and pitch/roll
// are tied to zero.
//
// Ports:
//   clk      in  system clock
//   rst      in  synchronous active-high reset
//   INT      in  IMU data-ready interrupt (asynchronous, active-high)
//   done     in  monarch transaction complete (sticky until next wrt)
//   rd_data  in  monarch receive word, register byte in [7:0]
//   wrt      out one-cycle transaction start strobe
//   wt_data  out command word, stable from wrt until the matching done rise
//   yaw      out yaw-rate sample
//   pitch    out pitch-rate sample
//   roll     out roll-rate sample
//   vld      out one-cycle strobe, samples update in the same cycle
//   ready    out configuration finished
module inert_seq
  import inert_pkg::*;
#(
  parameter int unsigned INIT_CYCLES = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] wt_data,
  output logic [15:0] yaw,
  output logic [15:0] pitch,
  output logic [15:0] roll,
  output logic        vld,
  output logic        ready
);

  localparam int unsigned CntW = $clog2(INIT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(INIT_CYCLES - 1);

  inert_state_t    state_q;
  logic [CntW-1:0] cnt_q;
  logic            done_q;
  logic            pending_q;
  logic [7:0]      lo_q;
  logic [15:0]     yaw_s_q;

  logic            int_rise;
  logic            done_rise;
  logic            consume;

  // Only the register byte is meaningful in the monarch word.
  logic            unused_rd_hi;
  assign unused_rd_hi = ^rd_data[15:8];

  int_sync u_int_sync (
    .clk    (clk),
    .rst    (rst),
    .async_i(INT),
    .rise_o (int_rise)
  );

  // A rise coinciding with our own wrt belongs to an older transaction (e.g.
  // one abandoned by reset); a real completion cannot arrive that early.
  assign done_rise = done & ~done_q & ~wrt;
  assign consume   = (state_q == StIdle) && pending_q;

`ifdef INERT_PITCH_ROLL_EN
  logic [15:0] pitch_s_q;
  logic [15:0] roll_s_q;
`else
  assign pitch = 16'h0000;
  assign roll  = 16'h0000;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StInitWait;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      pending_q <= 1'b0;
      lo_q      <= 8'h00;
      yaw_s_q   <= 16'h0000;
      wrt       <= 1'b0;
      wt_data   <= 16'h0000;
      yaw       <= 16'h0000;
      vld       <= 1'b0;
      ready     <= 1'b0;
`ifdef INERT_PITCH_ROLL_EN
      pitch_s_q <= 16'h0000;
      roll_s_q  <= 16'h0000;
      pitch     <= 16'h0000;
      roll      <= 16'h0000;
`endif
    end else begin
      done_q <= done;
      wrt    <= 1'b0;
      vld    <= 1'b0;
      // Edges collapse into one flag; nothing is remembered before ready.
      pending_q <= ready & (int_rise | (pending_q & ~consume));

      unique case (state_q)
        StInitWait: begin
          if (cnt_q == CntLast) begin
            state_q <= StCfg1;
            wrt     <= 1'b1;
            wt_data <= CFG_INT1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StCfg1: begin
          if (done_rise) begin
            state_q <= StCfg2;
            wrt     <= 1'b1;
            wt_data <= CFG_ODR;
          end
        end
        StCfg2: begin
          if (done_rise) begin
            state_q <= StCfg3;
            wrt     <= 1'b1;
            wt_data <= CFG_ROUND;
          end
        end
        StCfg3: begin
          if (done_rise) begin
            state_q <= StIdle;
            ready   <= 1'b1;
          end
        end
        StIdle: begin
          if (pending_q) begin
            state_q <= StRdYl;
            wrt     <= 1'b1;
            wt_data <= rd_cmd(ADDR_YAW_L);
          end
        end
        StRdYl: begin
          if (done_rise) begin
            lo_q    <= rd_data[7:0];
            state_q <= StRdYh;
            wrt     <= 1'b1;
            wt_data <= rd_cmd(ADDR_YAW_H);
          end
        end
        StRdYh: begin
          if (done_rise) begin
            yaw_s_q <= {rd_data[7:0], lo_q};
`ifdef INERT_PITCH_ROLL_EN
            state_q <= StRdPl;
            wrt     <= 1'b1;
            wt_data <= rd_cmd(ADDR_PITCH_L);
`else
            state_q <= StVld;
`endif
          end
        end
`ifdef INERT_PITCH_ROLL_EN
        StRdPl: begin
          if (done_rise) begin
            lo_q    <= rd_data[7:0];
            state_q <= StRdPh;
            wrt     <= 1'b1;
            wt_data <= rd_cmd(ADDR_PITCH_H);
          end
        end
        StRdPh: begin
          if (done_rise) begin
            pitch_s_q <= {rd_data[7:0], lo_q};
            state_q   <= StRdRl;
            wrt       <= 1'b1;
            wt_data   <= rd_cmd(ADDR_ROLL_L);
          end
        end
        StRdRl: begin
          if (done_rise) begin
            lo_q    <= rd_data[7:0];
            state_q <= StRdRh;
            wrt     <= 1'b1;
            wt_data <= rd_cmd(ADDR_ROLL_H);
          end
        end
        StRdRh: begin
          if (done_rise) begin
            roll_s_q <= {rd_data[7:0], lo_q};
            state_q  <= StVld;
          end
        end
`endif
        StVld: begin
          // Samples are staged until here so outputs never show a torn pair.
          yaw     <= yaw_s_q;
`ifdef INERT_PITCH_ROLL_EN
          pitch   <= pitch_s_q;
          roll    <= roll_s_q;
`endif
          vld     <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StInitWait;
      endcase
    end
  end

endmodule

// File: tb/tb_inert_seq.sv
// tb_inert_seq: scoreboard bench for inert_seq with a behavioural SPI monarch.
// Expected commands and samples are queued by the stimulus; a monitor pops
// and compares whenever the DUT strobes wrt or vld.
module tb_inert_seq;

  localparam int unsigned InitCycles = 16;
`ifdef INERT_PITCH_ROLL_EN
  localparam int NTx = 6;
  localparam logic [15:0] ExpPitch = 16'h5678;
  localparam logic [15:0] ExpRoll  = 16'h9ABC;
`else
  localparam int NTx = 2;
  localparam logic [15:0] ExpPitch = 16'h0000;
  localparam logic [15:0] ExpRoll  = 16'h0000;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        INT = 1'b0;
  logic        done = 1'b0;
  logic [15:0] rd_data = 16'h0000;
  logic        wrt;
  logic [15:0] wt_data;
  logic [15:0] yaw;
  logic [15:0] pitch;
  logic [15:0] roll;
  logic        vld;
  logic        ready;

  inert_seq #(.INIT_CYCLES(InitCycles)) dut (
    .clk    (clk),
    .rst    (rst),
    .INT    (INT),
    .done   (done),
    .rd_data(rd_data),
    .wrt    (wrt),
    .wt_data(wt_data),
    .yaw    (yaw),
    .pitch  (pitch),
    .roll   (roll),
    .vld    (vld),
    .ready  (ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] y;
    logic [15:0] p;
    logic [15:0] r;
  } sample_t;

  logic [15:0] exp_cmd[$];
  sample_t     exp_smp[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_wrt = 0;
  int n_vld = 0;
  int wrt_cyc = 0;
  int vld_cyc = 0;
  int rise_cyc = 0;
  int rise_cnt = 0;

  // Monarch model knobs and register file.
  int         lat = 3;
  int         hold_cycles = 0;
  logic       busy = 1'b0;
  logic [7:0] mem[128];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_wrt(input int target, input int budget, input string name);
    int k = 0;
    while (n_wrt < target && k < budget) begin
      tick();
      k++;
    end
    check(name, n_wrt, target);
  endtask

  task automatic wait_vld(input int target, input int budget, input string name);
    int k = 0;
    while (n_vld < target && k < budget) begin
      tick();
      k++;
    end
    check(name, n_vld, target);
  endtask

  task automatic pulse_int();
    INT = 1'b1;
    tick();
    tick();
    INT = 1'b0;
  endtask

  task automatic push_cfg();
    exp_cmd.push_back(16'h0D02);
    exp_cmd.push_back(16'h1160);
    exp_cmd.push_back(16'h1440);
  endtask

  task automatic push_read(input logic [15:0] y);
    sample_t s;
    exp_cmd.push_back(16'hA600);
    exp_cmd.push_back(16'hA700);
`ifdef INERT_PITCH_ROLL_EN
    exp_cmd.push_back(16'hA200);
    exp_cmd.push_back(16'hA300);
    exp_cmd.push_back(16'hA400);
    exp_cmd.push_back(16'hA500);
`endif
    s.y = y;
    s.p = ExpPitch;
    s.r = ExpRoll;
    exp_smp.push_back(s);
  endtask

  // Monarch: done drops on wrt (optionally after hold_cycles), rises lat
  // cycles later with the addressed byte; upper byte is junk on purpose.
  initial begin : monarch
    int hcnt;
    int lcnt;
    logic [15:0] cur;
    hcnt = 0;
    lcnt = 0;
    cur  = 16'h0000;
    forever begin
      @(negedge clk);
      if (wrt) begin
        checks++;
        if (busy) begin
          failures++;
          $display("FAIL no_early_wrt: got wrt %h while %h busy, required idle", wt_data, cur);
        end
        busy = 1'b1;
        cur  = wt_data;
        hcnt = hold_cycles;
        lcnt = lat;
        if (hcnt == 0) done = 1'b0;
      end else if (busy) begin
        if (hcnt > 0) begin
          hcnt--;
          if (hcnt == 0) done = 1'b0;
        end else begin
          lcnt--;
          if (lcnt <= 0) begin
            rd_data  = cur[15] ? {8'hA5, mem[cur[14:8]]} : 16'hA500;
            done     = 1'b1;
            busy     = 1'b0;
            rise_cnt++;
            rise_cyc = cyc;
          end
        end
      end
    end
  end

  initial begin : monitor
    logic [15:0] prev_wt;
    logic [15:0] prev_y;
    logic [15:0] prev_p;
    logic [15:0] prev_r;
    logic        prev_vld;
    logic        rst_s;
    logic [15:0] e;
    sample_t     s;
    prev_wt  = 16'h0000;
    prev_y   = 16'h0000;
    prev_p   = 16'h0000;
    prev_r   = 16'h0000;
    prev_vld = 1'b0;
    forever begin
      @(posedge clk);
      rst_s = rst;
      #1;
      if (wrt) begin
        n_wrt++;
        wrt_cyc = cyc;
        if (exp_cmd.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_wrt: got %h required no command", wt_data);
        end else begin
          e = exp_cmd.pop_front();
          check("cmd", wt_data, e);
        end
      end else if (!rst_s && wt_data !== prev_wt) begin
        check("wt_data_hold", wt_data, prev_wt);
      end
      if (vld) begin
        n_vld++;
        vld_cyc = cyc;
        check("vld_single", prev_vld, 1'b0);
        if (exp_smp.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_vld: got yaw %h required no sample", yaw);
        end else begin
          s = exp_smp.pop_front();
          check("yaw", yaw, s.y);
          check("pitch", pitch, s.p);
          check("roll", roll, s.r);
        end
      end else if (!rst_s) begin
        if (yaw !== prev_y) check("yaw_hold", yaw, prev_y);
        if (pitch !== prev_p) check("pitch_hold", pitch, prev_p);
        if (roll !== prev_r) check("roll_hold", roll, prev_r);
      end
      prev_wt  = wt_data;
      prev_y   = yaw;
      prev_p   = pitch;
      prev_r   = roll;
      prev_vld = vld;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int t0;
    int base;
    int k;
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    mem[7'h22] = 8'h78;
    mem[7'h23] = 8'h56;
    mem[7'h24] = 8'hBC;
    mem[7'h25] = 8'h9A;

    // Reset values.
    repeat (3) tick();
    check("rst_wrt", wrt, 1'b0);
    check("rst_wt_data", wt_data, 16'h0000);
    check("rst_yaw", yaw, 16'h0000);
    check("rst_pitch", pitch, 16'h0000);
    check("rst_roll", roll, 16'h0000);
    check("rst_vld", vld, 1'b0);
    check("rst_ready", ready, 1'b0);

    // Configuration; an interrupt during init must be discarded.
    push_cfg();
    rst = 1'b0;
    t0  = cyc;
    tick();
    tick();
    pulse_int();
    wait_wrt(1, 40, "first_wrt_seen");
    check("init_latency", wrt_cyc - t0, InitCycles);
    k = 0;
    while (rise_cnt < 3 && k < 100) begin
      tick();
      k++;
    end
    check("cfg_done_rises", rise_cnt, 3);
    check("ready_before_last_done", ready, 1'b0);
    tick();
    check("ready_after_last_done", ready, 1'b1);
    repeat (20) tick();
    check("early_int_ignored_wrt", n_wrt, 3);
    check("early_int_ignored_vld", n_vld, 0);

    // Single read sequence from IDLE.
    mem[7'h26] = 8'h34;
    mem[7'h27] = 8'h12;
    push_read(16'h1234);
    t0 = cyc;
    pulse_int();
    wait_wrt(4, 20, "first_read_wrt");
    check("int_to_wrt", wrt_cyc - t0, 4);
    wait_vld(1, 300, "vld_seq1");
    check("done_to_vld", vld_cyc - rise_cyc, 2);
    repeat (5) tick();

    // done still high from the last transaction when wrt issues.
    hold_cycles = 5;
    mem[7'h26] = 8'hCD;
    mem[7'h27] = 8'hAB;
    push_read(16'hABCD);
    pulse_int();
    wait_vld(2, 400, "vld_held_done");
    hold_cycles = 0;
    repeat (5) tick();

    // Three edges during one sequence collapse into one extra sequence.
    lat  = 10;
    base = n_wrt;
    mem[7'h26] = 8'h11;
    mem[7'h27] = 8'h22;
    push_read(16'h2211);
    push_read(16'h2211);
    pulse_int();
    wait_wrt(base + 1, 20, "collapse_first_wrt");
    repeat (3) begin
      pulse_int();
      tick();
      tick();
    end
    wait_vld(4, 600, "collapse_vld");
    repeat (40) tick();
    check("collapse_vld_total", n_vld, 4);
    check("collapse_wrt_total", n_wrt, base + 2 * NTx);

    // Reset in the middle of the yaw high-byte read.
    lat  = 8;
    base = n_wrt;
    mem[7'h26] = 8'h77;
    mem[7'h27] = 8'h66;
    exp_cmd.push_back(16'hA600);
    exp_cmd.push_back(16'hA700);
    pulse_int();
    wait_wrt(base + 2, 60, "rdyh_wrt");
    tick();
    rst = 1'b1;
    tick();
    check("rst2_wrt", wrt, 1'b0);
    check("rst2_wt_data", wt_data, 16'h0000);
    check("rst2_yaw", yaw, 16'h0000);
    check("rst2_vld", vld, 1'b0);
    check("rst2_ready", ready, 1'b0);
    tick();
    push_cfg();
    rst = 1'b0;
    t0  = cyc;
    wait_wrt(base + 3, 40, "reinit_wrt");
    check("reinit_latency", wrt_cyc - t0, InitCycles);
    k = 0;
    while (!ready && k < 200) begin
      tick();
      k++;
    end
    check("reinit_ready", ready, 1'b1);
    check("yaw_cleared", yaw, 16'h0000);
    push_read(16'h6677);
    pulse_int();
    wait_vld(5, 400, "vld_after_reinit");
    repeat (10) tick();

    check("cmd_queue_empty", exp_cmd.size(), 0);
    check("smp_queue_empty", exp_smp.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
